// File: rtl/decrypt_iter_pkg.sv
// Shared AES-128 parameters, tables and helper functions for the iterative
// encryption and decryption cores.
package decrypt_iter_pkg;

  localparam int N_K = 128;
  localparam int N_B = 128;
  localparam int N_R = 10;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Round constant for key-schedule step i (1..10); zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  // K(i-1) -> K(i) using Rcon[i]
  function automatic logic [127:0] key_step_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // K(i) -> K(i-1) using Rcon[i]
  function automatic logic [127:0] key_step_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0]  ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ sub_rot(p3) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/decrypt_iter_dec_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless 'last' is set, InvMixColumns. Purely combinational.
module dec_round
  import decrypt_iter_pkg::*;
(
  input  logic [N_B-1:0] state_in,
  input  logic [N_B-1:0] round_key,
  input  logic           last,
  output logic [N_B-1:0] state_out
);

  logic [7:0] keyed [16];

  // Undo the row rotation, invert the S-box and mix in the round key, byte by byte.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      int col;
      int row;
      int src;
      col = i / 4;
      row = i % 4;
      src = ((col - row + 4) % 4) * 4 + row;
      keyed[i] = INV_SBOX[state_in[N_B-1-8*src -: 8]] ^ round_key[N_B-1-8*i -: 8];
    end
  end

  // Apply InvMixColumns per column, bypassed on the final round.
  always_comb begin
    state_out = '0;
    for (int col = 0; col < 4; col++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = keyed[col*4];
      a1 = keyed[col*4+1];
      a2 = keyed[col*4+2];
      a3 = keyed[col*4+3];
      if (last) begin
        state_out[N_B-1-32*col -: 32] = {a0, a1, a2, a3};
      end else begin
        state_out[N_B-1-32*col -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
        };
      end
    end
  end

endmodule

// File: rtl/decrypt_iter.sv
// Iterative AES-128 decryption core behind a 4-phase req/ack handshake.
// Expands the key forward to K10, then walks the schedule back one round per cycle.
// Optional feature: define DECRYPT_ITER_KEY_CACHE_EN to remember the last
// key/K10 pair and skip key expansion when the same key is reused.
module decrypt_iter
  import decrypt_iter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] c,
  output logic [N_B-1:0] m,
  input  logic           req,
  output logic           ack
);

  state_t         state;
  state_t         state_next;
  logic [N_B-1:0] s;
  logic [N_K-1:0] rk;
  logic [3:0]     rcnt;
  logic [N_K-1:0] kp;
  logic [N_B-1:0] round_out;
  logic           cache_hit;
  logic [N_K-1:0] rk_load;
  logic [3:0]     rcnt_load;

  assign kp        = key_step_inv(rk, rcon(rcnt));
  assign rcnt_load = cache_hit ? 4'(N_R) : 4'd1;

  dec_round u_dec_round (
    .state_in  (s),
    .round_key (kp),
    .last      (rcnt == 4'd1),
    .state_out (round_out)
  );

`ifdef DECRYPT_ITER_KEY_CACHE_EN
  logic           cache_valid;
  logic [N_K-1:0] cache_key;
  logic [N_K-1:0] cache_k10;
  logic [N_K-1:0] key_reg;

  assign cache_hit = cache_valid && (k == cache_key);
  assign rk_load   = cache_hit ? cache_k10 : k;

  // Capture the request key and record the key/K10 pair once K10 is in rk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
      cache_k10   <= '0;
      key_reg     <= '0;
    end else begin
      if (state == IDLE && req) key_reg <= k;
      if (state == INIT) begin
        cache_valid <= 1'b1;
        cache_key   <= key_reg;
        cache_k10   <= rk;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign rk_load   = k;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic for the transaction sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = cache_hit ? INIT : KEYEXP;
      KEYEXP:  if (rcnt == 4'(N_R)) state_next = INIT;
      INIT:    state_next = ROUND;
      ROUND:   if (rcnt == 4'd1) state_next = DONE;
      DONE:    if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture inputs, expand the key, then run the inverse rounds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s    <= '0;
      rk   <= '0;
      rcnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            s    <= c;
            rk   <= rk_load;
            rcnt <= rcnt_load;
          end
        end
        KEYEXP: begin
          rk   <= key_step_fwd(rk, rcon(rcnt));
          rcnt <= (rcnt == 4'(N_R)) ? 4'(N_R) : rcnt + 4'd1;
        end
        INIT: begin
          s <= s ^ rk;
        end
        ROUND: begin
          s    <= round_out;
          rk   <= kp;
          rcnt <= rcnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign ack = (state == DONE);
  assign m   = ack ? s : '0;

endmodule

// File: tb/tb_decrypt_iter.sv
// Self-checking bench for decrypt_iter: known-answer vectors, latency,
// handshake corner cases, mid-transaction reset and random round trips.
module tb_decrypt_iter;
  import decrypt_iter_pkg::*;

`ifdef DECRYPT_ITER_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int MAX_WAIT = 100;
  localparam int RST_OFF  = CACHE ? 7 : 17;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] k;
  logic [127:0] c;
  logic [127:0] m;
  logic         req;
  logic         ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic         hit;
  } vec_t;

  vec_t vecs [6];

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_M  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_M   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_C   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  decrypt_iter dut (
    .clk (clk),
    .rst (rst),
    .k   (k),
    .c   (c),
    .m   (m),
    .req (req),
    .ack (ack)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference forward cipher used to build random round-trip vectors.
  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]  st  [16];
    logic [7:0]  tmp [16];
    logic [31:0] w   [4];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int j = 0; j < 4; j++) w[j] = key[127-32*j -: 32];
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = SBOX[st[i]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          st[col*4+row] = tmp[((col + row) % 4)*4 + row];
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = st[col*4]; a1 = st[col*4+1]; a2 = st[col*4+2]; a3 = st[col*4+3];
          st[col*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[col*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[col*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[col*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      t = {SBOX[w[3][23:16]], SBOX[w[3][15:8]], SBOX[w[3][7:0]], SBOX[w[3][31:24]]} ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count edges until ack rises, bounded so a stuck core cannot hang the run.
  task automatic wait_ack(inout int lat);
    while (lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack) break;
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] key, input logic [127:0] ct, output int lat);
    @(negedge clk);
    k   = key;
    c   = ct;
    req = 1'b1;
    lat = 0;
    wait_ack(lat);
  endtask

  task automatic release_req(input string name);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check_output(name, 128'(ack), 128'(0));
  endtask

  // Main test sequence.
  initial begin
    int lat;
    int exp_lat;
    logic [127:0] rkey, rpt, rct;

    vecs[0] = '{C1_K, C1_C, C1_M, 1'b0};
    vecs[1] = '{C1_K, C1_C, C1_M, 1'b1};
    vecs[2] = '{B_K,  B_C,  B_M,  1'b0};
    vecs[3] = '{128'h0, Z_C, 128'h0, 1'b0};
    vecs[4] = '{128'h0, Z_C, 128'h0, 1'b1};
    vecs[5] = '{C1_K, C1_C, C1_M, 1'b0};

    rst = 1'b0;
    req = 1'b0;
    k   = '0;
    c   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ack", 128'(ack), 128'(0));
    check_output("reset_m", m, 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Known-answer vectors with latency and handshake release.
    for (int i = 0; i < 6; i++) begin
      exp_lat = (CACHE && vecs[i].hit) ? 12 : 22;
      apply_stimulus(vecs[i].key, vecs[i].ct, lat);
      check_output($sformatf("vec%0d_m", i), m, vecs[i].pt);
      check_output($sformatf("vec%0d_latency", i), 128'(lat), 128'(exp_lat));
      release_req($sformatf("vec%0d_ackdrop", i));
    end

    // One-cycle req pulse, inputs scrambled right after capture.
    @(negedge clk);
    k   = B_K;
    c   = B_C;
    req = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    @(negedge clk);
    req = 1'b0;
    k   = {$urandom, $urandom, $urandom, $urandom};
    c   = {$urandom, $urandom, $urandom, $urandom};
    wait_ack(lat);
    check_output("pulse_m", m, B_M);
    check_output("pulse_latency", 128'(lat), 128'(22));
    @(posedge clk);
    #1;
    check_output("pulse_ack_one_cycle", 128'(ack), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check_output("pulse_no_restart", 128'(ack), 128'(0));

    // req held high across DONE: ack stays up and nothing restarts.
    apply_stimulus(C1_K, C1_C, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("hold%0d_ack", i), 128'(ack), 128'(1));
    end
    check_output("hold_m", m, C1_M);
    release_req("hold_ackdrop");
    repeat (3) @(posedge clk);
    #1;
    check_output("hold_idle", 128'(ack), 128'(0));

    // Reset in ROUND with rcnt=5, then full-latency recovery.
    apply_stimulus(C1_K, C1_C, lat);
    release_req("prerst_ackdrop");
    @(negedge clk);
    k   = C1_K;
    c   = C1_C;
    req = 1'b1;
    @(posedge clk);
    repeat (RST_OFF - 1) @(posedge clk);
    @(negedge clk);
    check_output("prerst_state", 128'(dut.state == ROUND), 128'(1));
    check_output("prerst_rcnt", 128'(dut.rcnt), 128'(5));
    rst = 1'b0;
    req = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_ack", 128'(ack), 128'(0));
    check_output("rst_m", m, 128'h0);
    check_output("rst_state", 128'(dut.state == IDLE), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(C1_K, C1_C, lat);
    check_output("postrst_m", m, C1_M);
    check_output("postrst_latency", 128'(lat), 128'(22));
    release_req("postrst_ackdrop");

    // Random round trips against the reference encryptor.
    for (int i = 0; i < 200; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rct  = aes_encrypt(rkey, rpt);
      apply_stimulus(rkey, rct, lat);
      check_output($sformatf("rand%0d_m", i), m, rpt);
      release_req($sformatf("rand%0d_ackdrop", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
